// File: rtl/sram_stream_ctrl.sv
// Streams a vector from SRAM port A to a valid/ready output and an input
// stream into SRAM port B, with a one-cycle done pulse when both sides finish.
module sram_stream_ctrl #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_rd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_wr_base,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic                  done,
    output logic                  CENA,
    output logic                  WENA,
    output logic [ADDR_WIDTH-1:0] AA,
    input  logic [BITS-1:0]       QA,
    output logic                  CENB,
    output logic                  WENB,
    output logic [ADDR_WIDTH-1:0] AB,
    output logic [BITS-1:0]       DB
);

    localparam int unsigned IW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    state_t                state_nxt;

    logic [IW-1:0]         len_q;
    logic [IW-1:0]         rd_idx;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         pop_cnt;
    logic [ADDR_WIDTH-1:0] rd_base_q;
    logic [ADDR_WIDTH-1:0] wr_base_q;

    logic [BITS-1:0]       fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  inflight;

    logic                  accept;
    logic                  pop;
    logic                  issue;
    logic                  wr_fire;
    logic                  rd_more;
    logic                  wr_more;
    logic                  fin;
    logic [2:0]            slots_used;

    // Handshake and issue decisions
    always_comb begin
        out_valid  = (occ != 2'd0);
        out_data   = fifo_mem[rd_ptr];
        pop        = out_valid && out_ready;
        rd_more    = (rd_idx < len_q);
        wr_more    = (wr_idx < len_q);
        slots_used = 3'(occ) + 3'(inflight) - 3'(pop);
        issue      = (state == RUN) && rd_more && (slots_used < 3'd2);
        in_ready   = (state == RUN) && wr_more;
        wr_fire    = in_valid && in_ready;
        accept     = (state == IDLE) && cmd_valid;
        fin        = (rd_idx == len_q) && (occ == 2'd0) && !inflight &&
                     (pop_cnt == len_q) && (wr_idx == len_q);
    end

    // SRAM pins; addresses and data are forced to zero when the port is idle
    always_comb begin
        CENA = !issue;
        WENA = 1'b1;
        AA   = issue ? rd_base_q + ADDR_WIDTH'(rd_idx) : '0;
        CENB = !wr_fire;
        WENB = !wr_fire;
        AB   = wr_fire ? wr_base_q + ADDR_WIDTH'(wr_idx) : '0;
        DB   = wr_fire ? in_data : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = RUN;
            end
            RUN:  if (fin) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_q     <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
            pop_cnt   <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
        end else if (accept) begin
            len_q     <= IW'(cmd_len);
            rd_base_q <= cmd_rd_base;
            wr_base_q <= cmd_wr_base;
            rd_idx    <= '0;
            wr_idx    <= '0;
            pop_cnt   <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue)    rd_idx  <= rd_idx + IW'(1);
            if (wr_fire)  wr_idx  <= wr_idx + IW'(1);
            if (inflight) wr_ptr  <= ~wr_ptr;
            if (pop) begin
                pop_cnt <= pop_cnt + IW'(1);
                rd_ptr  <= ~rd_ptr;
            end
            occ <= occ + 2'(inflight) - 2'(pop);
        end
    end

    // QA is valid in the cycle after a read was issued
    always_ff @(posedge CLK) begin
        if (inflight) fifo_mem[wr_ptr] <= QA;
    end

endmodule
